// File: rtl/stream_demux.sv
// Two-way stream demultiplexer: one upstream port steered into two
// independent DEPTH-entry FIFOs, each draining to its own output channel.
module stream_demux_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  assign rdata = valid ? mem[rd_ptr] : '0;

  // Storage needs no reset; the empty-gated read port hides stale data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end

endmodule

module stream_demux #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sel_i,
  output logic              a_valid_o,
  input  logic              a_ready_i,
  output logic [DATA_W-1:0] a_data_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  output logic [DATA_W-1:0] b_data_o,
  output logic [CW-1:0]     a_count_o,
  output logic [CW-1:0]     b_count_o
);

  logic a_full;
  logic b_full;
  logic a_push;
  logic b_push;
  logic a_pop;
  logic b_pop;

  // Ready reflects only the target buffer's fullness, never a same-cycle pop.
  assign in_ready_o = in_sel_i ? !b_full : !a_full;

  assign a_push = in_valid_i && in_ready_o && !in_sel_i;
  assign b_push = in_valid_i && in_ready_o &&  in_sel_i;
  assign a_pop  = a_valid_o && a_ready_i;
  assign b_pop  = b_valid_o && b_ready_i;

  stream_demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (a_push),
    .wdata   (in_data_i),
    .pop     (a_pop),
    .full    (a_full),
    .valid   (a_valid_o),
    .rdata   (a_data_o),
    .count   (a_count_o)
  );

  stream_demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (b_push),
    .wdata   (in_data_i),
    .pop     (b_pop),
    .full    (b_full),
    .valid   (b_valid_o),
    .rdata   (b_data_o),
    .count   (b_count_o)
  );

endmodule

// File: tb/tb_stream_demux.sv
// Directed vector table plus hand-written sequences and a
// queue-scoreboard random run for stream_demux.
module tb_stream_demux;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk;
  logic       reset_n;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_data_i;
  logic       in_sel_i;
  logic       a_valid_o;
  logic       a_ready_i;
  logic [7:0] a_data_o;
  logic       b_valid_o;
  logic       b_ready_i;
  logic [7:0] b_data_o;
  logic [1:0] a_count_o;
  logic [1:0] b_count_o;

  int n_chk;
  int n_fail;

  stream_demux #(
    .DATA_W (8),
    .DEPTH  (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_sel_i   (in_sel_i),
    .a_valid_o  (a_valid_o),
    .a_ready_i  (a_ready_i),
    .a_data_o   (a_data_o),
    .b_valid_o  (b_valid_o),
    .b_ready_i  (b_ready_i),
    .b_data_o   (b_data_o),
    .a_count_o  (a_count_o),
    .b_count_o  (b_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       s;
    logic [7:0] d;
    logic       ar;
    logic       br;
    logic       rdy;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic [1:0] ac;
    logic [1:0] bc;
  } vec_t;

  vec_t tbl [30];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input logic ar, input logic br);
    in_valid_i = v;
    in_sel_i   = s;
    in_data_i  = d;
    a_ready_i  = ar;
    b_ready_i  = br;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    drive(L, L, 8'h00, L, L);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] got [$];
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] nxt;
    logic       ok;
    int         cyc;

    n_chk  = 0;
    n_fail = 0;

    tbl[0]  = '{H, L, 8'hA5, H, H, H, L, 8'h00, L, 8'h00, 2'd0, 2'd0};
    tbl[1]  = '{H, H, 8'h3C, H, H, H, H, 8'hA5, L, 8'h00, 2'd1, 2'd0};
    tbl[2]  = '{L, L, 8'h00, H, H, H, L, 8'h00, H, 8'h3C, 2'd0, 2'd1};
    tbl[3]  = '{L, L, 8'h00, H, H, H, L, 8'h00, L, 8'h00, 2'd0, 2'd0};
    tbl[4]  = '{H, L, 8'h01, L, H, H, L, 8'h00, L, 8'h00, 2'd0, 2'd0};
    tbl[5]  = '{H, L, 8'h02, L, H, H, H, 8'h01, L, 8'h00, 2'd1, 2'd0};
    tbl[6]  = '{L, L, 8'h00, L, H, L, H, 8'h01, L, 8'h00, 2'd2, 2'd0};
    tbl[7]  = '{L, H, 8'h00, L, H, H, H, 8'h01, L, 8'h00, 2'd2, 2'd0};
    tbl[8]  = '{H, L, 8'h77, L, H, L, H, 8'h01, L, 8'h00, 2'd2, 2'd0};
    tbl[9]  = '{L, L, 8'h00, H, H, L, H, 8'h01, L, 8'h00, 2'd2, 2'd0};
    tbl[10] = '{L, L, 8'h00, H, H, H, H, 8'h02, L, 8'h00, 2'd1, 2'd0};
    tbl[11] = '{L, L, 8'h00, H, H, H, L, 8'h00, L, 8'h00, 2'd0, 2'd0};
    tbl[12] = '{H, L, 8'h11, L, H, H, L, 8'h00, L, 8'h00, 2'd0, 2'd0};
    tbl[13] = '{H, L, 8'h22, L, H, H, H, 8'h11, L, 8'h00, 2'd1, 2'd0};
    tbl[14] = '{H, L, 8'h33, H, H, L, H, 8'h11, L, 8'h00, 2'd2, 2'd0};
    tbl[15] = '{L, L, 8'h00, H, H, H, H, 8'h22, L, 8'h00, 2'd1, 2'd0};
    tbl[16] = '{L, L, 8'h00, H, H, H, L, 8'h00, L, 8'h00, 2'd0, 2'd0};
    tbl[17] = '{H, L, 8'h44, L, H, H, L, 8'h00, L, 8'h00, 2'd0, 2'd0};
    tbl[18] = '{H, L, 8'h55, H, H, H, H, 8'h44, L, 8'h00, 2'd1, 2'd0};
    tbl[19] = '{L, L, 8'h00, L, H, H, H, 8'h55, L, 8'h00, 2'd1, 2'd0};
    tbl[20] = '{L, L, 8'h00, H, H, H, H, 8'h55, L, 8'h00, 2'd1, 2'd0};
    tbl[21] = '{L, L, 8'h00, H, H, H, L, 8'h00, L, 8'h00, 2'd0, 2'd0};
    tbl[22] = '{H, L, 8'h66, L, L, H, L, 8'h00, L, 8'h00, 2'd0, 2'd0};
    tbl[23] = '{H, L, 8'h67, L, L, H, H, 8'h66, L, 8'h00, 2'd1, 2'd0};
    tbl[24] = '{H, H, 8'h88, L, L, H, H, 8'h66, L, 8'h00, 2'd2, 2'd0};
    tbl[25] = '{H, H, 8'h99, H, L, H, H, 8'h66, H, 8'h88, 2'd2, 2'd1};
    tbl[26] = '{L, L, 8'h00, L, L, H, H, 8'h67, H, 8'h88, 2'd1, 2'd2};
    tbl[27] = '{L, H, 8'h00, H, H, L, H, 8'h67, H, 8'h88, 2'd1, 2'd2};
    tbl[28] = '{L, L, 8'h00, H, H, H, L, 8'h00, H, 8'h99, 2'd0, 2'd1};
    tbl[29] = '{L, L, 8'h00, H, H, H, L, 8'h00, L, 8'h00, 2'd0, 2'd0};

    do_reset();
    #1;
    chk("rst_a_valid", 32'(a_valid_o), 0);
    chk("rst_b_valid", 32'(b_valid_o), 0);
    chk("rst_a_count", 32'(a_count_o), 0);
    chk("rst_b_count", 32'(b_count_o), 0);
    chk("rst_in_ready", 32'(in_ready_o), 1);

    // Directed table: expectations describe the state before each edge.
    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ar, tbl[i].br);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready_o), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_a_valid", i), 32'(a_valid_o), 32'(tbl[i].av));
      chk($sformatf("v%0d_a_data", i), 32'(a_data_o), 32'(tbl[i].ad));
      chk($sformatf("v%0d_b_valid", i), 32'(b_valid_o), 32'(tbl[i].bv));
      chk($sformatf("v%0d_b_data", i), 32'(b_data_o), 32'(tbl[i].bd));
      chk($sformatf("v%0d_a_count", i), 32'(a_count_o), 32'(tbl[i].ac));
      chk($sformatf("v%0d_b_count", i), 32'(b_count_o), 32'(tbl[i].bc));
      next_cycle();
    end

    // Wrap-around: ten beats into B while its consumer toggles ready.
    nxt = 8'd0;
    cyc = 0;
    while ((got.size() < 10) && (cyc < 100)) begin
      drive(nxt < 8'd10, H, nxt, L, 1'(cyc));
      #1;
      chk("wrap_b_count_max", 32'(b_count_o <= 2'd2), 1);
      if (b_valid_o && b_ready_i) got.push_back(b_data_o);
      if (in_valid_i && in_ready_o) nxt = nxt + 8'd1;
      next_cycle();
      cyc++;
    end
    chk("wrap_received", got.size(), 10);
    for (int i = 0; i < got.size(); i++) begin
      chk($sformatf("wrap_beat%0d", i), 32'(got[i]), i);
    end
    drive(L, L, 8'h00, H, H);
    repeat (3) next_cycle();

    // Mid-operation reset with both buffers full.
    drive(H, L, 8'hA1, L, L); next_cycle();
    drive(H, L, 8'hA2, L, L); next_cycle();
    drive(H, H, 8'hB1, L, L); next_cycle();
    drive(H, H, 8'hB2, L, L); next_cycle();
    drive(L, L, 8'h00, L, L);
    #1;
    chk("full_a_count", 32'(a_count_o), 2);
    chk("full_b_count", 32'(b_count_o), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_a_valid", 32'(a_valid_o), 0);
    chk("mrst_b_valid", 32'(b_valid_o), 0);
    chk("mrst_a_data", 32'(a_data_o), 0);
    chk("mrst_b_data", 32'(b_data_o), 0);
    chk("mrst_a_count", 32'(a_count_o), 0);
    chk("mrst_b_count", 32'(b_count_o), 0);
    chk("mrst_ready_sel0", 32'(in_ready_o), 1);
    in_sel_i = H;
    #1;
    chk("mrst_ready_sel1", 32'(in_ready_o), 1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(H, L, 8'hFF, L, L);
    next_cycle();
    drive(L, L, 8'h00, L, L);
    #1;
    chk("post_rst_a_valid", 32'(a_valid_o), 1);
    chk("post_rst_a_data", 32'(a_data_o), 32'hFF);
    chk("post_rst_a_count", 32'(a_count_o), 1);
    chk("post_rst_b_valid", 32'(b_valid_o), 0);

    // Random run against a two-queue scoreboard.
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      drive(1'($urandom_range(1)), 1'($urandom_range(1)),
            8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
      #1;
      ok = 1'b1;
      if (a_valid_o !== (qa.size() != 0)) ok = 1'b0;
      if (b_valid_o !== (qb.size() != 0)) ok = 1'b0;
      if (a_data_o !== ((qa.size() != 0) ? qa[0] : 8'h00)) ok = 1'b0;
      if (b_data_o !== ((qb.size() != 0) ? qb[0] : 8'h00)) ok = 1'b0;
      if (32'(a_count_o) !== qa.size()) ok = 1'b0;
      if (32'(b_count_o) !== qb.size()) ok = 1'b0;
      if (in_ready_o !== (in_sel_i ? (qb.size() < 2) : (qa.size() < 2)))
        ok = 1'b0;
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got av=%0b ad=%0h ac=%0d bv=%0b bd=%0h bc=%0d rdy=%0b expected ac=%0d bc=%0d",
                 c, a_valid_o, a_data_o, a_count_o, b_valid_o, b_data_o,
                 b_count_o, in_ready_o, qa.size(), qb.size());
      end
      if (a_ready_i && (qa.size() != 0)) void'(qa.pop_front());
      if (b_ready_i && (qb.size() != 0)) void'(qb.pop_front());
      if (in_valid_i) begin
        if (in_sel_i && (qb.size() + (b_ready_i && b_valid_o ? 1 : 0) < 2))
          qb.push_back(in_data_i);
        else if (!in_sel_i &&
                 (qa.size() + (a_ready_i && a_valid_o ? 1 : 0) < 2))
          qa.push_back(in_data_i);
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output buffer; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid_i  input  1  upstream beat valid.
REQ-006 SHALL have port in_ready_o  output  1  block can accept the presented beat.
REQ-007 SHALL have port in_data_i  input  DATA_W  upstream payload.
REQ-008 SHALL have port in_sel_i  input  1  destination: 0 = channel A, 1 = channel B.
REQ-009 SHALL have port a_valid_o  output  1  channel A beat valid.
REQ-010 SHALL have port a_ready_i  input  1  channel A consumer ready.
REQ-011 SHALL have port a_data_o  output  DATA_W  channel A payload.
REQ-012 SHALL have port b_valid_o  output  1  channel B beat valid.
REQ-013 SHALL have port b_ready_i  input  1  channel B consumer ready.
REQ-014 SHALL have port b_data_o  output  DATA_W  channel B payload.
REQ-015 SHALL have port a_count_o  output  $clog2(DEPTH)+1  entries held in buffer A.
REQ-016 SHALL have port b_count_o  output  $clog2(DEPTH)+1  entries held in buffer B.

Function
REQ-017 SHALL contain one independent circular FIFO of DEPTH entries per channel, each with its own read pointer, write pointer and count.
REQ-018 SHALL drive in_ready_o combinationally as NOT full of the buffer selected by in_sel_i; it SHALL NOT depend on in_valid_i.
REQ-019 SHALL accept a beat when in_valid_i and in_ready_o are both 1 at a rising edge, writing in_data_i into the selected buffer only.
REQ-020 SHALL drive x_valid_o = 1 exactly when buffer x count is nonzero; x_data_o = oldest entry of buffer x, or 0 when the buffer is empty.
REQ-021 SHALL pop buffer x when x_valid_o and x_ready_i are both 1 at a rising edge.
REQ-022 SHALL give a minimum latency of 1 cycle: a beat accepted at edge N is visible on x_valid_o/x_data_o after edge N; there is no combinational input-to-output bypass.
REQ-023 SHALL hold x_data_o stable while x_valid_o = 1 and x_ready_i = 0.
REQ-024 SHALL preserve per-channel order; no ordering is implied between channels.
REQ-025 SHALL, on a simultaneous push and pop of the same non-empty buffer, leave the count unchanged and update both pointers.
REQ-026 SHALL, when a buffer is full and popped in the same cycle, still deassert in_ready_o for that channel in that cycle; the push is not accepted.
REQ-027 SHALL allow a pop of one channel and a push of the other in the same cycle.
REQ-028 SHALL wrap each pointer modulo DEPTH; count SHALL range 0..DEPTH and never overflow or underflow.
REQ-029 SHALL let a full buffer backpressure only its own channel: with A full, beats with in_sel_i = 1 are still accepted.

Reset
REQ-030 SHALL, on reset_n = 0, immediately (asynchronously) clear all pointers and counts, giving a_valid_o = b_valid_o = 0, a_data_o = b_data_o = 0 and a_count_o = b_count_o = 0.
REQ-031 SHALL discard all buffered entries on reset asserted mid-operation; in_ready_o = 1 for both selections while reset_n = 0.
REQ-032 SHALL resume normal operation on the first rising edge after reset_n deasserts.

Verification
REQ-033 Bench SHALL cover basic routing: push 8'hA5 with sel = 0, then 8'h3C with sel = 1, both ready_i = 1 -> a_data_o = A5 one cycle after its push, b_data_o = 3C one cycle after its push, each valid for exactly 1 cycle.
REQ-034 Bench SHALL cover fill and backpressure: a_ready_i = 0, push 8'h01, 8'h02 with sel = 0 -> a_count_o = 2, in_ready_o = 0 when sel = 0 and 1 when sel = 1; then a_ready_i = 1 -> 01 and then 02 emerge in order.
REQ-035 Bench SHALL cover simultaneous push/pop: A holds 1 entry, push 8'h55 to A while popping A -> a_count_o stays 1, next a_data_o = 55.
REQ-036 Bench SHALL cover wrap-around: 10 sequential beats 0..9 to B with b_ready_i toggling every cycle -> all 10 received on B in order, none lost, none duplicated, b_count_o <= 2 throughout.
REQ-037 Bench SHALL cover mid-operation reset: both buffers full, assert reset_n = 0 between edges -> valids, data and counts read 0 immediately; after release, a push of 8'hFF to A appears on the next cycle.
REQ-038 Bench SHALL cover a randomized run: 1000 cycles with random valid, sel, data and ready_i checked against a scoreboard of two queues -> zero mismatches.
